hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Produces the active-high hold (enx) inputs for the F/D/E/M stage registers, the bubble-insertion flushes and the forwarding selects.
- Tracks two multi-cycle conditions in sequential logic: a busy counter for the iterative mult/div unit (MDU), and a wait/timeout FSM for data-memory handshakes.

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, stall, flush and forwarding controller
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 32,
  parameter int MEM_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] writereg_e,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [REG_W-1:0] writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             memtoreg_m,
  input  logic             branch_d,
  input  logic             hilo_read_d,
  input  logic             mdu_start_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_e,
  output logic             flush_m,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mdu_busy,
  output logic             mem_tmo
);

  localparam int CNT_W = $clog2(MDU_LAT);
  // The request cycle spent in IDLE already counts as the first wait cycle,
  // so the WAIT-state counter trips one step before the full limit.
  localparam int TMO_AT = (MEM_TMO >= 2) ? MEM_TMO - 2 : 0;
  localparam int WAIT_W = (TMO_AT > 0) ? $clog2(TMO_AT + 1) : 1;
  localparam logic [CNT_W-1:0]  MDU_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(TMO_AT);

  typedef enum logic {IDLE, WAIT} mem_state_t;

  mem_state_t        state, state_next;
  logic [CNT_W-1:0]  mdu_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic lu_stall, br_stall, hilo_stall, mdu_conf, mem_stall;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign mdu_busy   = (mdu_cnt != '0);
  assign mem_tmo    = (state == WAIT) && (wait_cnt == WAIT_END) && !mem_ready;
  assign mem_stall  = mem_req_m && !mem_ready && !mem_tmo;
  assign mdu_conf   = mdu_start_e && mdu_busy;
  assign hilo_stall = hilo_read_d && mdu_busy;
  assign lu_stall   = memtoreg_e && (hit(writereg_e, rs_d) || hit(writereg_e, rt_d));
  assign br_stall   = branch_d &&
                      ((regwrite_e && (hit(writereg_e, rs_d) || hit(writereg_e, rt_d))) ||
                       (memtoreg_m && (hit(writereg_m, rs_d) || hit(writereg_m, rt_d))));

  // Memory handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Wait counter: cleared while idle, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    wait_cnt <= '0;
    else if (state == IDLE)                     wait_cnt <= '0;
    else if (state_next == WAIT)                wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // MDU busy counter runs independently of pipeline holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           mdu_cnt <= '0;
    else if (mdu_start_e && !stall_e && !mdu_busy)     mdu_cnt <= MDU_LOAD;
    else if (mdu_busy)                                 mdu_cnt <= mdu_cnt - CNT_W'(1);
  end

  // Next memory state plus prioritised stall/flush/forward outputs.
  always_comb begin
    state_next = state;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    fwd_a_d    = 1'b0;
    fwd_b_d    = 1'b0;
    fwd_a_e    = 2'b00;
    fwd_b_e    = 2'b00;

    case (state)
      IDLE: if (mem_req_m && !mem_ready) state_next = WAIT;
      WAIT: if (mem_ready || mem_tmo)    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (mdu_conf) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hilo_stall || lu_stall || br_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end

      fwd_a_d = regwrite_m && hit(writereg_m, rs_d);
      fwd_b_d = regwrite_m && hit(writereg_m, rt_d);

      if (regwrite_m && hit(writereg_m, rs_e))      fwd_a_e = 2'b10;
      else if (regwrite_w && hit(writereg_w, rs_e)) fwd_a_e = 2'b01;

      if (regwrite_m && hit(writereg_m, rt_e))      fwd_b_e = 2'b10;
      else if (regwrite_w && hit(writereg_w, rt_e)) fwd_b_e = 2'b01;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int MDU_LAT = 4;
  localparam int MEM_TMO = 4;

  logic       clk, rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic       branch_d, hilo_read_d, mdu_start_e, mem_req_m, mem_ready;
  logic       stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       mdu_busy, mem_tmo;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.REG_W(5), .MDU_LAT(MDU_LAT), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .hilo_read_d(hilo_read_d), .mdu_start_e(mdu_start_e),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .flush_m(flush_m), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mdu_busy(mdu_busy), .mem_tmo(mem_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_f,stall_d,stall_e,stall_m,flush_e,flush_m,fwd_a_d,fwd_b_d,fwd_a_e,fwd_b_e,mdu_busy,mem_tmo}
  wire [13:0] out_vec = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_m,
                         fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_busy, mem_tmo};
  wire [5:0]  sf_vec  = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_m};

  // Reference model: cycles of MDU work left, and whether/how long M has been waiting.
  int   m_left = 0;
  bit   m_waiting = 0;
  int   m_waited = 0;
  logic [13:0] m_exp;

  function automatic bit same(input int a, input int b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [13:0] model_out();
    bit busy, tmo, ms, conf, lu, br, other;
    logic [3:0] st;
    logic fe, fm;
    logic [1:0] fa, fb;
    if (rst) return 14'd0;
    busy  = (m_left > 0);
    tmo   = m_waiting && (m_waited == MEM_TMO - 1) && !mem_ready;
    ms    = mem_req_m && !mem_ready && !tmo;
    conf  = mdu_start_e && busy;
    lu    = memtoreg_e && (same(writereg_e, rs_d) || same(writereg_e, rt_d));
    br    = branch_d && ((regwrite_e && (same(writereg_e, rs_d) || same(writereg_e, rt_d))) ||
                         (memtoreg_m && (same(writereg_m, rs_d) || same(writereg_m, rt_d))));
    other = (hilo_read_d && busy) || lu || br;
    st = 4'b0000; fe = 1'b0; fm = 1'b0;
    if (ms)         st = 4'b1111;
    else if (conf)  begin st = 4'b1110; fm = 1'b1; end
    else if (other) begin st = 4'b1100; fe = 1'b1; end
    fa = (regwrite_m && same(writereg_m, rs_e)) ? 2'd2 : (regwrite_w && same(writereg_w, rs_e)) ? 2'd1 : 2'd0;
    fb = (regwrite_m && same(writereg_m, rt_e)) ? 2'd2 : (regwrite_w && same(writereg_w, rt_e)) ? 2'd1 : 2'd0;
    return {st, fe, fm, regwrite_m && same(writereg_m, rs_d), regwrite_m && same(writereg_m, rt_d),
            fa, fb, busy, tmo};
  endfunction

  always_comb m_exp = model_out();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_waiting <= 0; m_waited <= 0;
    end else begin
      if (mdu_start_e && !m_exp[11] && m_left == 0) m_left <= MDU_LAT - 1;
      else if (m_left > 0)                          m_left <= m_left - 1;
      if (m_waiting) begin
        if (mem_ready || m_exp[0]) m_waiting <= 0;
        else                       m_waited <= m_waited + 1;
      end else if (mem_req_m && !mem_ready) begin
        m_waiting <= 1; m_waited <= 1;
      end
    end
  end

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0; memtoreg_m = 0;
    branch_d = 0; hilo_read_d = 0; mdu_start_e = 0; mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin @(negedge clk); idle_inputs(); end
  endtask

  task automatic test_reset();
    memtoreg_e = 1; writereg_e = 5; rs_d = 5; regwrite_m = 1; writereg_m = 7; rs_e = 7;
    mem_req_m = 1; hilo_read_d = 1;
    @(negedge clk); #1;
    n_checks++;
    if (out_vec !== 14'd0) begin n_errors++; $display("FAIL reset_outputs: got %b need 0", out_vec); end
    @(negedge clk); idle_inputs(); rst = 0; #1;
    n_checks++;
    if (out_vec !== 14'd0) begin n_errors++; $display("FAIL after_reset: got %b need 0", out_vec); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle_inputs(); memtoreg_e = 1; writereg_e = 5; rs_d = 5; #1;
    n_checks++;
    if (sf_vec !== 6'b110010) begin n_errors++; $display("FAIL load_use: got %b need 110010", sf_vec); end
    @(negedge clk); writereg_e = 0; rs_d = 0; #1;
    n_checks++;
    if (sf_vec !== 6'b000000) begin n_errors++; $display("FAIL load_use_r0: got %b need 000000", sf_vec); end
    @(negedge clk); idle_inputs(); branch_d = 1; regwrite_e = 1; writereg_e = 4; rt_d = 4; #1;
    n_checks++;
    if (sf_vec !== 6'b110010) begin n_errors++; $display("FAIL branch_e: got %b need 110010", sf_vec); end
    @(negedge clk); regwrite_e = 0; memtoreg_m = 1; writereg_m = 4; #1;
    n_checks++;
    if (sf_vec !== 6'b110010) begin n_errors++; $display("FAIL branch_m: got %b need 110010", sf_vec); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_forwarding();
    @(negedge clk); idle_inputs();
    regwrite_m = 1; regwrite_w = 1; writereg_m = 7; writereg_w = 7; rs_e = 7; rt_e = 3; #1;
    n_checks++;
    if (fwd_a_e !== 2'b10) begin n_errors++; $display("FAIL fwd_a_e_m: got %b need 10", fwd_a_e); end
    n_checks++;
    if (fwd_b_e !== 2'b00) begin n_errors++; $display("FAIL fwd_b_e_none: got %b need 00", fwd_b_e); end
    @(negedge clk); regwrite_m = 0; #1;
    n_checks++;
    if (fwd_a_e !== 2'b01) begin n_errors++; $display("FAIL fwd_a_e_w: got %b need 01", fwd_a_e); end
    @(negedge clk); regwrite_m = 1; writereg_m = 0; writereg_w = 0; rs_e = 0; #1;
    n_checks++;
    if (fwd_a_e !== 2'b00) begin n_errors++; $display("FAIL fwd_a_e_r0: got %b need 00", fwd_a_e); end
    @(negedge clk); writereg_m = 9; rs_d = 9; rt_d = 2; #1;
    n_checks++;
    if ({fwd_a_d, fwd_b_d} !== 2'b10) begin n_errors++; $display("FAIL fwd_d: got %b need 10", {fwd_a_d, fwd_b_d}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_mdu();
    int n;
    @(negedge clk); idle_inputs(); mdu_start_e = 1; #1;
    n_checks++;
    if ({sf_vec, mdu_busy} !== 7'b0000000) begin n_errors++; $display("FAIL mdu_start: got %b need 0000000", {sf_vec, mdu_busy}); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mdu_start_e = 0; hilo_read_d = 1; #1;
      if (sf_vec == 6'b110010) n++;
    end
    n_checks++;
    if (n != MDU_LAT - 1) begin n_errors++; $display("FAIL hilo_stall_cycles: got %0d need %0d", n, MDU_LAT - 1); end
    n_checks++;
    if (mdu_busy !== 1'b0) begin n_errors++; $display("FAIL mdu_idle: got %b need 0", mdu_busy); end
    @(negedge clk); hilo_read_d = 0; mdu_start_e = 1; #1;
    @(negedge clk); mdu_start_e = 1; #1;
    n_checks++;
    if (sf_vec !== 6'b111001) begin n_errors++; $display("FAIL mdu_conf: got %b need 111001", sf_vec); end
    drain();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs(); mem_req_m = 1; #1;
      n_checks++;
      if (sf_vec !== 6'b111100) begin n_errors++; $display("FAIL mem_wait_%0d: got %b need 111100", i, sf_vec); end
    end
    @(negedge clk); mem_ready = 1; #1;
    n_checks++;
    if ({sf_vec, mem_tmo} !== 7'b0000000) begin n_errors++; $display("FAIL mem_ready: got %b need 0000000", {sf_vec, mem_tmo}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs(); mem_req_m = 1; #1;
      n_checks++;
      if ({sf_vec, mem_tmo} !== 7'b1111000) begin n_errors++; $display("FAIL tmo_wait_%0d: got %b need 1111000", i, {sf_vec, mem_tmo}); end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({sf_vec, mem_tmo} !== 7'b0000001) begin n_errors++; $display("FAIL tmo_pulse: got %b need 0000001", {sf_vec, mem_tmo}); end
    @(negedge clk); mem_req_m = 0; #1;
    n_checks++;
    if (mem_tmo !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got %b need 0", mem_tmo); end
    @(negedge clk); mem_req_m = 1; #1;
    n_checks++;
    if ({sf_vec, mem_tmo} !== 7'b1111000) begin n_errors++; $display("FAIL tmo_rearm: got %b need 1111000", {sf_vec, mem_tmo}); end
    @(negedge clk); mem_ready = 1;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_priority();
    @(negedge clk); idle_inputs(); mem_req_m = 1; memtoreg_e = 1; writereg_e = 5; rs_d = 5; #1;
    n_checks++;
    if (sf_vec !== 6'b111100) begin n_errors++; $display("FAIL prio_mem_lu: got %b need 111100", sf_vec); end
    @(negedge clk); mem_ready = 1; #1;
    n_checks++;
    if (sf_vec !== 6'b110010) begin n_errors++; $display("FAIL prio_lu_only: got %b need 110010", sf_vec); end
    @(negedge clk); idle_inputs(); mdu_start_e = 1;
    @(negedge clk); mdu_start_e = 1; memtoreg_e = 1; writereg_e = 6; rt_d = 6; #1;
    n_checks++;
    if (sf_vec !== 6'b111001) begin n_errors++; $display("FAIL prio_conf_lu: got %b need 111001", sf_vec); end
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_inputs(); mdu_start_e = 1;
    @(negedge clk); mdu_start_e = 0; mem_req_m = 1;
    @(negedge clk); hilo_read_d = 1; memtoreg_e = 1; writereg_e = 3; rs_d = 3;
    #2 rst = 1; #1;
    n_checks++;
    if (out_vec !== 14'd0) begin n_errors++; $display("FAIL reset_mid: got %b need 0", out_vec); end
    @(negedge clk); idle_inputs(); rst = 0; hilo_read_d = 1; #1;
    n_checks++;
    if (out_vec !== 14'd0) begin n_errors++; $display("FAIL post_reset_idle: got %b need 0", out_vec); end
    @(negedge clk); idle_inputs(); mem_req_m = 1; mem_ready = 1; #1;
    n_checks++;
    if (sf_vec !== 6'b000000) begin n_errors++; $display("FAIL post_reset_mem: got %b need 000000", sf_vec); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      writereg_e = 5'($urandom_range(0, 3)); writereg_m = 5'($urandom_range(0, 3));
      writereg_w = 5'($urandom_range(0, 3));
      regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      memtoreg_e = ($urandom_range(0, 3) == 0); memtoreg_m = ($urandom_range(0, 3) == 0);
      branch_d = ($urandom_range(0, 3) == 0); hilo_read_d = ($urandom_range(0, 3) == 0);
      mdu_start_e = ($urandom_range(0, 5) == 0);
      mem_req_m = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if (out_vec !== m_exp) begin n_errors++; $display("FAIL random_%0d: got %b need %b", i, out_vec, m_exp); end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mdu();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
